// File: rtl/demux_reg_8.sv
// Eight-slot write-side register bank: one word steered into one of eight
// registered slots, with per-slot valid flags and a one-cycle write ack.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous active-high reset (highest priority)
//   clear      synchronous flush of all slots and valid flags
//   we         write enable
//   select     slot index 0..7 (don't-care when we=0)
//   data       word to store
//   out0..out7 registered slot contents
//   valid      valid[i]=1 when slot i written since last reset/clear
//   ack        high for the cycle after an accepted write
//   ack_sel    slot index of the acknowledged write
module demux_reg_8 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [7:0]       valid,
  output logic             ack,
  output logic [2:0]       ack_sel
);

  logic [WIDTH-1:0] slot [8];
  logic [7:0]       wen;

  // One-hot enable; select is only looked at when we=1, so an
  // undriven select on idle cycles cannot disturb any slot.
  always_comb begin
    wen = '0;
    if (we) begin
      wen[select] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        slot[i] <= '0;
      end
      valid   <= '0;
      ack     <= 1'b0;
      ack_sel <= '0;
    end else if (clear) begin
      // Flush drops any concurrent write; ack_sel keeps its last value.
      for (int i = 0; i < 8; i++) begin
        slot[i] <= '0;
      end
      valid <= '0;
      ack   <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wen[i]) begin
          slot[i] <= data;
        end
      end
      valid <= valid | wen;
      ack   <= we;
      if (we) begin
        ack_sel <= select;
      end
    end
  end

  assign out0 = slot[0];
  assign out1 = slot[1];
  assign out2 = slot[2];
  assign out3 = slot[3];
  assign out4 = slot[4];
  assign out5 = slot[5];
  assign out6 = slot[6];
  assign out7 = slot[7];

endmodule

// File: tb/tb_demux_reg_8.sv
// Bench for demux_reg_8: directed plan steps followed by random traffic,
// every cycle compared against a slot-array reference model.
module tb_demux_reg_8;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  select;
  logic [31:0] data;
  logic        clear;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  valid;
  logic        ack;
  logic [2:0]  ack_sel;

  logic [31:0] dout [8];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_out [8];
  logic [7:0]  m_valid;
  logic        m_ack;
  logic [2:0]  m_sel;

  always #5 clock = ~clock;

  demux_reg_8 #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .select  (select),
    .data    (data),
    .clear   (clear),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3),
    .out4    (out4),
    .out5    (out5),
    .out6    (out6),
    .out7    (out7),
    .valid   (valid),
    .ack     (ack),
    .ack_sel (ack_sel)
  );

  assign dout[0] = out0;
  assign dout[1] = out1;
  assign dout[2] = out2;
  assign dout[3] = out3;
  assign dout[4] = out4;
  assign dout[5] = out5;
  assign dout[6] = out6;
  assign dout[7] = out7;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("out%0d", i), dout[i], m_out[i]);
    end
    chk("valid", {24'd0, valid}, {24'd0, m_valid});
    chk("ack", {31'd0, ack}, {31'd0, m_ack});
    chk("ack_sel", {29'd0, ack_sel}, {29'd0, m_sel});
  endtask

  // Apply one cycle of inputs, advance the model by the priority rules,
  // then compare everything just after the edge.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [2:0] s, input logic [31:0] d);
    reset  = r;
    clear  = c;
    we     = w;
    select = w ? s : 3'bxxx;
    data   = d;
    @(posedge clock);
    #1;
    if (r) begin
      for (int i = 0; i < 8; i++) m_out[i] = 32'd0;
      m_valid = 8'h00;
      m_ack   = 1'b0;
      m_sel   = 3'd0;
    end else if (c) begin
      for (int i = 0; i < 8; i++) m_out[i] = 32'd0;
      m_valid = 8'h00;
      m_ack   = 1'b0;
    end else if (w) begin
      m_out[s]   = d;
      m_valid[s] = 1'b1;
      m_ack      = 1'b1;
      m_sel      = s;
    end else begin
      m_ack = 1'b0;
    end
    compare_all();
  endtask

  initial begin
    reset  = 1'b1;
    clear  = 1'b0;
    we     = 1'b0;
    select = 3'd0;
    data   = 32'd0;

    // Reset held with a pending write
    step(1, 0, 1, 3'd3, 32'hDEADBEEF);
    step(1, 0, 1, 3'd3, 32'hDEADBEEF);
    chk("rst_valid", {24'd0, valid}, 32'h0);

    // Single write then idle
    step(0, 0, 1, 3'd5, 32'h12345678);
    chk("single_out5", out5, 32'h12345678);
    chk("single_valid", {24'd0, valid}, 32'h20);
    chk("single_ack", {31'd0, ack}, 32'd1);
    step(0, 0, 0, 3'd0, 32'h0);
    chk("single_ack_drop", {31'd0, ack}, 32'd0);
    chk("single_hold", out5, 32'h12345678);

    // Back-to-back sweep
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 3'(i), 32'h1000_0000 + i);
      chk("sweep_ack", {31'd0, ack}, 32'd1);
      chk("sweep_sel", {29'd0, ack_sel}, i);
    end
    chk("sweep_valid", {24'd0, valid}, 32'hFF);
    chk("sweep_out7", out7, 32'h1000_0007);

    // Same-slot overwrite
    step(0, 0, 1, 3'd2, 32'hAAAA_AAAA);
    step(0, 0, 1, 3'd2, 32'h5555_5555);
    chk("ovw_out2", out2, 32'h5555_5555);
    chk("ovw_out3", out3, 32'h1000_0003);

    // Clear wins over a concurrent write
    step(0, 1, 1, 3'd4, 32'hFFFF_FFFF);
    chk("clr_out4", out4, 32'h0);
    chk("clr_valid", {24'd0, valid}, 32'h0);
    chk("clr_sel_hold", {29'd0, ack_sel}, 32'd2);

    // Reset right after a write
    step(0, 0, 1, 3'd6, 32'hCAFE_F00D);
    step(1, 0, 0, 3'd0, 32'h0);
    chk("rstmid_out6", out6, 32'h0);
    chk("rstmid_ack", {31'd0, ack}, 32'd0);
    step(0, 0, 1, 3'd1, 32'h0BAD_CAFE);
    chk("rstmid_out1", out1, 32'h0BAD_CAFE);
    step(0, 0, 0, 3'd0, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)),
           32'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
